apb_loader: RTL
===============

Name: apb_loader

Overview:
- Byte-stream-driven APB initiator: a second bus master alongside the CPU.
- Turns framed commands from a host byte channel (console/debug link) into APB word writes and reads, and returns results on a byte channel.
- Used to load or inspect SRAM and the system region while the CPU is held via cpu_hold.
- Sits on the same APB signal set as the CPU: paddr, pdata, prdata, psel, penable, pwrite, pstb, pready, perr.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (fixed: 4 byte lanes)
TIMEOUT, 1024, max ACCESS cycles waiting for pready before abort

Ports:
clk  in  1  clock
APB_PRESETn  in  1  asynchronous active-low reset
rx_valid  in  1  host byte available
rx_data  in  8  host byte
rx_ready  out  1  byte accepted when rx_valid&rx_ready
tx_valid  out  1  response byte available
tx_data  out  8  response byte
tx_ready  in  1  sink accepts when tx_valid&tx_ready
APB_paddr  out  ADDR_WIDTH  address
APB_pdata  out  DATA_WIDTH  write data
APB_prdata  in  DATA_WIDTH  read data
APB_psel  out  1  select
APB_penable  out  1  enable
APB_pwrite  out  1  1=write
APB_pstb  out  4  byte strobes
APB_pready  in  1  responder ready
APB_perr  in  1  responder error
cpu_hold  out  1  CPU stall request
err  out  1  sticky error flag

Behaviour:
- Reset (async, APB_PRESETn=0): state=CMD. rx_ready=0, tx_valid=0, tx_data=0, APB_paddr=0, APB_pdata=0, APB_psel=0, APB_penable=0, APB_pwrite=0, APB_pstb=0, cpu_hold=0, err=0. All counters cleared.
- Reset mid-transaction drops psel/penable immediately; no response byte is sent.
- Frame format: cmd byte, then 4 address bytes (LSB first), then 4 data bytes (LSB first) for write only.
- Commands:
  - 0x57 'W': write.
  - 0x52 'R': read.
  - 0x48 'H': set cpu_hold=1. Response 0x06.
  - 0x47 'G': clear cpu_hold. Response 0x06.
  - Any other cmd byte: discarded, err=1, response 0x15.
- States and transitions:
  - CMD: rx_ready=1. Accepted byte is decoded as above.
  - ADDR: rx_ready=1. Shift 4 bytes into the address register with a 2-bit counter. After byte 4: W->DATA, R->SETUP.
  - DATA: rx_ready=1. Shift 4 bytes into the data register. After byte 4 -> SETUP.
  - SETUP: one cycle. psel=1, penable=0, paddr/pdata/pwrite valid, pstb=4'hF for write, 4'h0 for read. -> ACCESS.
  - ACCESS: psel=1, penable=1. Wait counter increments each cycle.
    - On pready=1: sample perr and prdata (read), drop psel/penable the next cycle, -> RESP.
    - If the counter reaches TIMEOUT-1 without pready: drop psel/penable, treat as error, -> RESP.
  - RESP: emit bytes one per tx handshake; tx_valid is held with tx_data stable until tx_ready.
    - Write: 0x06 (ok) or 0x15 (perr/timeout).
    - Read ok: 4 prdata bytes LSB first, then 0x06.
    - Read error: 0x15 only.
    - After the last byte -> CMD.
- rx_ready=0 in SETUP, ACCESS and RESP; no bytes are consumed during a bus cycle.
- Latency: last frame byte accepted at cycle N -> SETUP at N+1, ACCESS from N+2. With zero-wait pready, first tx_valid at N+3.
- APB_paddr, APB_pdata and APB_pwrite are stable from SETUP through the last ACCESS cycle. pstb=0 whenever psel=0.
- err is sticky: set on perr, timeout or bad command; cleared only by reset.
- pready or perr while psel=0 is ignored.
- rx_valid and tx_ready may toggle arbitrarily; only the valid&ready cycle counts.
- cpu_hold is unaffected by errors; bus cycles are issued regardless of cpu_hold (host is responsible).

Test Plan:
- Write frame 57 00 10 00 00 EF BE AD DE, pready same cycle as penable -> one SETUP cycle then one ACCESS cycle; paddr=0x00001000, pdata=0xDEADBEEF, pwrite=1, pstb=F; tx byte 0x06; err=0.
- Read frame 52 04 10 00 00, responder returns 0x12345678 after 3 wait cycles -> tx bytes 78 56 34 12 06; paddr stable for all 4 ACCESS cycles.
- Write with perr=1 at pready -> tx 0x15, err=1; err stays 1 after a later successful write.
- No pready for TIMEOUT cycles -> psel drops after exactly TIMEOUT ACCESS cycles; tx 0x15; err=1; next frame is accepted normally.
- 'H' then 'G' with tx_ready held low 5 cycles -> cpu_hold 1 then 0; tx_data=0x06 held stable while stalled; bad cmd 0x00 -> tx 0x15.
- Assert reset during ACCESS -> psel, penable, tx_valid and cpu_hold are 0 immediately; after release, state is CMD and rx_ready=1.

Source files
------------

// File: rtl/apb_loader_if.sv
// APB signal bundle shared by the loader (master) and the addressed
// responder (slave).
//   paddr/pdata/psel/penable/pwrite/pstb : driven by the initiator
//   prdata/pready/perr                   : driven by the responder
interface apb_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [3:0]            pstb;
    logic                  pready;
    logic                  perr;

    modport master (
        output paddr, pdata, psel, penable, pwrite, pstb,
        input  prdata, pready, perr
    );

    modport slave (
        input  paddr, pdata, psel, penable, pwrite, pstb,
        output prdata, pready, perr
    );
endinterface

// File: rtl/apb_loader.sv
// Byte-stream driven APB initiator. Framed host commands arriving on the rx
// byte channel become APB word writes/reads; results go back on tx.
//   clk, APB_PRESETn        : clock, async active-low reset
//   rx_valid/rx_data/rx_ready : host command bytes in
//   tx_valid/tx_data/tx_ready : response bytes out
//   APB                     : APB master side (apb_loader_if.master)
//   cpu_hold                : CPU stall request ('H' sets, 'G' clears)
//   err                     : sticky error (perr, timeout, bad command)
module apb_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                APB_PRESETn,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    apb_loader_if.master        APB,
    output logic                cpu_hold,
    output logic                err
);
    localparam int        WW  = $clog2(TIMEOUT + 1);
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_DATA, S_SETUP, S_ACCESS, S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic                  is_wr_q, is_wr_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
    logic [2:0]            rcnt_q, rcnt_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [3:0]            pstb_q, pstb_d;
    logic                  hold_q, hold_d;
    logic                  err_q, err_d;

    logic rx_fire, tx_fire;
    assign rx_fire = rx_valid & rx_ready_q;
    assign tx_fire = tx_valid_q & tx_ready;

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        is_wr_d    = is_wr_q;
        wait_d     = wait_q;
        rbuf_d     = rbuf_q;
        rcnt_d     = rcnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        paddr_d    = paddr_q;
        pdata_d    = pdata_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        pstb_d     = pstb_q;
        hold_d     = hold_q;
        err_d      = err_q;

        case (state_q)
            S_CMD: if (rx_fire) begin
                bcnt_d = 2'd0;
                rcnt_d = 3'd0;
                case (rx_data)
                    8'h57: begin is_wr_d = 1'b1; state_d = S_ADDR; end
                    8'h52: begin is_wr_d = 1'b0; state_d = S_ADDR; end
                    8'h48: begin
                        hold_d = 1'b1; tx_valid_d = 1'b1; tx_data_d = ACK; state_d = S_RESP;
                    end
                    8'h47: begin
                        hold_d = 1'b0; tx_valid_d = 1'b1; tx_data_d = ACK; state_d = S_RESP;
                    end
                    default: begin
                        err_d = 1'b1; tx_valid_d = 1'b1; tx_data_d = NAK; state_d = S_RESP;
                    end
                endcase
            end
            // Address and data shift in LSB first straight into the bus
            // registers; they are idle (psel=0) while the frame arrives.
            S_ADDR: if (rx_fire) begin
                paddr_d = {rx_data, paddr_q[ADDR_WIDTH-1:8]};
                bcnt_d  = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    if (is_wr_q) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_SETUP; psel_d = 1'b1; pwrite_d = 1'b0; pstb_d = 4'h0;
                    end
                end
            end
            S_DATA: if (rx_fire) begin
                pdata_d = {rx_data, pdata_q[DATA_WIDTH-1:8]};
                bcnt_d  = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    state_d = S_SETUP; psel_d = 1'b1; pwrite_d = 1'b1; pstb_d = 4'hF;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                wait_d    = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                wait_d = wait_q + 1'b1;
                if (APB.pready || wait_q == WW'(TIMEOUT - 1)) begin
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    pwrite_d   = 1'b0;
                    pstb_d     = 4'h0;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP;
                    if (!APB.pready || APB.perr) begin
                        err_d = 1'b1; tx_data_d = NAK;
                    end else if (is_wr_q) begin
                        tx_data_d = ACK;
                    end else begin
                        // First read byte goes out now; the rest plus the ACK wait in rbuf.
                        tx_data_d = APB.prdata[7:0];
                        rbuf_d    = {ACK, APB.prdata[DATA_WIDTH-1:8]};
                        rcnt_d    = 3'd4;
                    end
                end
            end
            S_RESP: if (tx_fire) begin
                if (rcnt_q == 3'd0) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_CMD;
                end else begin
                    tx_data_d = rbuf_q[7:0];
                    rbuf_d    = rbuf_q >> 8;
                    rcnt_d    = rcnt_q - 3'd1;
                end
            end
            default: state_d = S_CMD;
        endcase

        rx_ready_d = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_DATA);
    end

    always_ff @(posedge clk or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            state_q    <= S_CMD;
            bcnt_q     <= '0;
            is_wr_q    <= 1'b0;
            wait_q     <= '0;
            rbuf_q     <= '0;
            rcnt_q     <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            paddr_q    <= '0;
            pdata_q    <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            pstb_q     <= '0;
            hold_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            is_wr_q    <= is_wr_d;
            wait_q     <= wait_d;
            rbuf_q     <= rbuf_d;
            rcnt_q     <= rcnt_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            paddr_q    <= paddr_d;
            pdata_q    <= pdata_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            pstb_q     <= pstb_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign APB.paddr   = paddr_q;
    assign APB.pdata   = pdata_q;
    assign APB.psel    = psel_q;
    assign APB.penable = penable_q;
    assign APB.pwrite  = pwrite_q;
    assign APB.pstb    = pstb_q;
    assign cpu_hold    = hold_q;
    assign err         = err_q;
endmodule
